// File: rtl/local_mem_avmm_bridge_pkg.sv
// rtl/local_mem_avmm_bridge_pkg.sv - shared widths and command layout for the local-memory Avalon-MM bridge
// Purpose: default bus widths, the default-width command record and a helper
//          that sizes the flattened command word for any width set.
// Ports:   none (package).
package local_mem_avmm_bridge_pkg;

  localparam int DEF_DATA_WIDTH       = 512;
  localparam int DEF_HDL_ADDR_WIDTH   = 27;
  localparam int DEF_BURSTCOUNT_WIDTH = 7;
  localparam int DEF_RESPONSE_WIDTH   = 2;

  // Command record at the default widths. The top rebuilds the same field
  // order at its own parameter values; cmd_width() keeps both in agreement.
  typedef struct packed {
    logic [DEF_HDL_ADDR_WIDTH-1:0]   address;
    logic [DEF_BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [DEF_DATA_WIDTH-1:0]       writedata;
    logic [DEF_DATA_WIDTH/8-1:0]     byteenable;
    logic                            read;
    logic                            write;
    logic                            debugaccess;
  } avmm_cmd_t;

  function automatic int cmd_width(input int data_w, input int addr_w, input int burst_w);
    return addr_w + burst_w + data_w + data_w / 8 + 3;
  endfunction

endpackage

// File: rtl/avmm_cmd_skid.sv
// rtl/avmm_cmd_skid.sv - registered command output stage with a one-entry skid buffer
// Purpose: forwards an opaque command word one cycle after acceptance, holds it
//          while downstream stalls, and absorbs the one command that can be
//          accepted in the stall cycle. Upstream stall is purely registered.
// Ports:   clk, rst_n (async active-low)
//          up_data/up_valid  command offered by the upstream master
//          up_wait           registered stall to upstream (skid full, or in reset)
//          dn_data           registered command to downstream (all-zero when idle)
//          dn_wait           downstream stall
module avmm_cmd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_wait,
  output logic [W-1:0] dn_data,
  input  logic         dn_wait
);

  logic         out_valid;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         out_free;

  assign accept   = up_valid && !up_wait;
  assign out_free = !out_valid || !dn_wait;

  // up_wait mirrors skid_valid except during reset, where it is held high.
  // A full skid always implies up_wait, so accept never coincides with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      dn_data    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      up_wait    <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        dn_data   <= skid_data;
        out_valid <= 1'b1;
      end else if (accept) begin
        dn_data   <= up_data;
        out_valid <= 1'b1;
      end else begin
        // Zeroing the idle word drops read/write straight from the flops.
        dn_data   <= '0;
        out_valid <= 1'b0;
      end
      skid_valid <= 1'b0;
      up_wait    <= 1'b0;
    end else if (accept) begin
      skid_data  <= up_data;
      skid_valid <= 1'b1;
      up_wait    <= 1'b1;
    end else begin
      up_wait <= skid_valid;
    end
  end

endmodule

// File: rtl/local_mem_avmm_bridge.sv
// rtl/local_mem_avmm_bridge.sv - single-clock Avalon-MM pipeline bridge for one local-memory bank
// Purpose: registers every s0->m0 command signal through avmm_cmd_skid and
//          returns m0 read responses to s0. Transparent apart from latency.
// Ports:   clk, reset_n (async active-low)
//          s0_*  slave port facing the AFU (command in, response out)
//          m0_*  master port facing the memory model (command out, response in)
// Config:  LOCAL_MEM_AVMM_BRIDGE_RSP_REG_EN defined  -> response path registered (1 cycle)
//          LOCAL_MEM_AVMM_BRIDGE_RSP_REG_EN undefined -> response path combinational
module local_mem_avmm_bridge
  import local_mem_avmm_bridge_pkg::*;
#(
  parameter int  DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int  HDL_ADDR_WIDTH   = DEF_HDL_ADDR_WIDTH,
  parameter int  BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH,
  parameter int  RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
  localparam int BYTEEN_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        s0_waitrequest,
  output logic [DATA_WIDTH-1:0]       s0_readdata,
  output logic                        s0_readdatavalid,
  output logic [RESPONSE_WIDTH-1:0]   s0_response,
  input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
  input  logic [DATA_WIDTH-1:0]       s0_writedata,
  input  logic [HDL_ADDR_WIDTH-1:0]   s0_address,
  input  logic                        s0_write,
  input  logic                        s0_read,
  input  logic [BYTEEN_WIDTH-1:0]     s0_byteenable,
  input  logic                        s0_debugaccess,
  input  logic                        m0_waitrequest,
  input  logic [DATA_WIDTH-1:0]       m0_readdata,
  input  logic                        m0_readdatavalid,
  input  logic [RESPONSE_WIDTH-1:0]   m0_response,
  output logic [BURSTCOUNT_WIDTH-1:0] m0_burstcount,
  output logic [DATA_WIDTH-1:0]       m0_writedata,
  output logic [HDL_ADDR_WIDTH-1:0]   m0_address,
  output logic                        m0_write,
  output logic                        m0_read,
  output logic [BYTEEN_WIDTH-1:0]     m0_byteenable,
  output logic                        m0_debugaccess
);

  typedef struct packed {
    logic [HDL_ADDR_WIDTH-1:0]   address;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEEN_WIDTH-1:0]     byteenable;
    logic                        read;
    logic                        write;
    logic                        debugaccess;
  } cmd_t;

  localparam int CMD_W = cmd_width(DATA_WIDTH, HDL_ADDR_WIDTH, BURSTCOUNT_WIDTH);

  cmd_t s0_cmd;
  cmd_t m0_cmd;

  assign s0_cmd = '{address:     s0_address,
                    burstcount:  s0_burstcount,
                    writedata:   s0_writedata,
                    byteenable:  s0_byteenable,
                    read:        s0_read,
                    write:       s0_write,
                    debugaccess: s0_debugaccess};

  // read and write together are forwarded untouched; no arbitration here.
  avmm_cmd_skid #(
    .W (CMD_W)
  ) u_cmd_skid (
    .clk      (clk),
    .rst_n    (reset_n),
    .up_data  (s0_cmd),
    .up_valid (s0_read | s0_write),
    .up_wait  (s0_waitrequest),
    .dn_data  (m0_cmd),
    .dn_wait  (m0_waitrequest)
  );

  assign m0_address     = m0_cmd.address;
  assign m0_burstcount  = m0_cmd.burstcount;
  assign m0_writedata   = m0_cmd.writedata;
  assign m0_byteenable  = m0_cmd.byteenable;
  assign m0_read        = m0_cmd.read;
  assign m0_write       = m0_cmd.write;
  assign m0_debugaccess = m0_cmd.debugaccess;

`ifdef LOCAL_MEM_AVMM_BRIDGE_RSP_REG_EN
  // No backpressure on responses: every m0 beat is copied once, next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_readdatavalid <= 1'b0;
      s0_readdata      <= '0;
      s0_response      <= '0;
    end else begin
      s0_readdatavalid <= m0_readdatavalid;
      s0_readdata      <= m0_readdata;
      s0_response      <= m0_response;
    end
  end
`else
  assign s0_readdatavalid = m0_readdatavalid;
  assign s0_readdata      = m0_readdata;
  assign s0_response      = m0_response;
`endif

endmodule

// File: tb/tb_local_mem_avmm_bridge.sv
// tb/tb_local_mem_avmm_bridge.sv - directed self-checking bench for local_mem_avmm_bridge
`timescale 1ns/1ps
module tb_local_mem_avmm_bridge;

  localparam int DW  = 512;
  localparam int AW  = 27;
  localparam int BW  = 7;
  localparam int BEW = DW / 8;
  localparam int RW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           s0_waitrequest;
  logic [DW-1:0]  s0_readdata;
  logic           s0_readdatavalid;
  logic [RW-1:0]  s0_response;
  logic [BW-1:0]  s0_burstcount;
  logic [DW-1:0]  s0_writedata;
  logic [AW-1:0]  s0_address;
  logic           s0_write;
  logic           s0_read;
  logic [BEW-1:0] s0_byteenable;
  logic           s0_debugaccess;
  logic           m0_waitrequest;
  logic [DW-1:0]  m0_readdata;
  logic           m0_readdatavalid;
  logic [RW-1:0]  m0_response;
  logic [BW-1:0]  m0_burstcount;
  logic [DW-1:0]  m0_writedata;
  logic [AW-1:0]  m0_address;
  logic           m0_write;
  logic           m0_read;
  logic [BEW-1:0] m0_byteenable;
  logic           m0_debugaccess;

  local_mem_avmm_bridge dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s0_response      (s0_response),
    .s0_burstcount    (s0_burstcount),
    .s0_writedata     (s0_writedata),
    .s0_address       (s0_address),
    .s0_write         (s0_write),
    .s0_read          (s0_read),
    .s0_byteenable    (s0_byteenable),
    .s0_debugaccess   (s0_debugaccess),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_response      (m0_response),
    .m0_burstcount    (m0_burstcount),
    .m0_writedata     (m0_writedata),
    .m0_address       (m0_address),
    .m0_write         (m0_write),
    .m0_read          (m0_read),
    .m0_byteenable    (m0_byteenable),
    .m0_debugaccess   (m0_debugaccess)
  );

  typedef struct packed {
    logic [AW-1:0]  address;
    logic [BW-1:0]  burstcount;
    logic [DW-1:0]  writedata;
    logic [BEW-1:0] byteenable;
    logic           read;
    logic           write;
    logic           debugaccess;
  } cmd_t;

  cmd_t m0_now, s0_now, prev_cmd;
  cmd_t m0_q[$];
  cmd_t s0_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rand_mode = 1'b0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic wait_seen = 1'b0;
  int   run_len = 0;
  int   max_run = 0;

  assign m0_now = {m0_address, m0_burstcount, m0_writedata, m0_byteenable, m0_read, m0_write, m0_debugaccess};
  assign s0_now = {s0_address, s0_burstcount, s0_writedata, s0_byteenable, s0_read, s0_write, s0_debugaccess};

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs only change 1ns after posedge, so negedge sees exactly what the next posedge samples.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      if (prev_stall) check("m0_hold_while_stalled", m0_now, prev_cmd);
      prev_stall = (m0_read | m0_write) && m0_waitrequest;
      prev_cmd   = m0_now;
      if ((m0_read | m0_write) && !m0_waitrequest) m0_q.push_back(m0_now);
      if ((s0_read | s0_write) && !s0_waitrequest) s0_q.push_back(s0_now);
      if (s0_waitrequest) wait_seen = 1'b1;
      if (m0_write && !m0_waitrequest) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) m0_waitrequest = 1'($urandom_range(0, 1));
    else if (stall_cnt > 0) begin
      m0_waitrequest = 1'b1;
      stall_cnt--;
    end else m0_waitrequest = 1'b0;
  endtask

  task automatic send(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic [DW-1:0] d, input logic [BEW-1:0] be, input string tag);
    logic acc;
    acc = 1'b0;
    s0_read = rd;  s0_write = wr;  s0_address = a;
    s0_burstcount = b;  s0_writedata = d;  s0_byteenable = be;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = !s0_waitrequest;
      tick();
    end
    check({tag, "_accepted"}, acc, 1'b1);
  endtask

  task automatic idle();
    s0_read  = 1'b0;
    s0_write = 1'b0;
  endtask

  task automatic rsp_beat(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] r, input string tag);
    m0_readdatavalid = v;  m0_readdata = d;  m0_response = r;
`ifdef LOCAL_MEM_AVMM_BRIDGE_RSP_REG_EN
    tick();
    #1;
`else
    #1;
`endif
    check({tag, "_valid"}, s0_readdatavalid, v);
    if (v) check({tag, "_data"}, s0_readdata, d);
    if (v) check({tag, "_resp"}, s0_response, r);
`ifndef LOCAL_MEM_AVMM_BRIDGE_RSP_REG_EN
    tick();
`endif
  endtask

  initial begin
    logic [DW-1:0] pat;
    reset_n = 1'b0;
    s0_read = 1'b0;  s0_write = 1'b0;  s0_address = '0;  s0_burstcount = '0;
    s0_writedata = '0;  s0_byteenable = '0;  s0_debugaccess = 1'b0;
    m0_waitrequest = 1'b0;  m0_readdata = '0;  m0_readdatavalid = 1'b0;  m0_response = '0;

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_read", m0_read, 1'b0);
    check("rst_m0_write", m0_write, 1'b0);
    check("rst_s0_rdv", s0_readdatavalid, 1'b0);
    check("rst_s0_wait", s0_waitrequest, 1'b1);
    check("rst_m0_address", m0_address, '0);
    reset_n = 1'b1;
    check("rst_wait_before_edge", s0_waitrequest, 1'b1);
    tick();
    check("rst_wait_after_edge", s0_waitrequest, 1'b0);

    // Single read: m0_read for exactly one cycle, one cycle after acceptance
    send(1'b1, 1'b0, 27'h123, 7'd4, '0, '1, "single_rd");
    idle();
    check("single_rd_m0_read", m0_read, 1'b1);
    check("single_rd_m0_write", m0_write, 1'b0);
    check("single_rd_addr", m0_address, 27'h123);
    check("single_rd_burst", m0_burstcount, 7'd4);
    tick();
    check("single_rd_m0_read_drop", m0_read, 1'b0);

    // 8 back-to-back writes against a 5-cycle stall
    m0_q.delete();
    m0_waitrequest = 1'b1;
    stall_cnt = 4;
    for (int i = 0; i < 8; i++) begin
      pat = {64{8'(8'h10 + i)}};
      send(1'b0, 1'b1, 27'(27'h40 + i), 7'd1, pat, '1, $sformatf("stall_wr%0d", i));
      if (i == 1) check("stall_s0_wait_asserted", s0_waitrequest, 1'b1);
    end
    idle();
    repeat (8) tick();
    check("stall_beat_count", m0_q.size(), 8);
    for (int i = 0; i < 8 && i < m0_q.size(); i++) begin
      pat = {64{8'(8'h10 + i)}};
      check($sformatf("stall_addr%0d", i), m0_q[i].address, 27'(27'h40 + i));
      check($sformatf("stall_data%0d", i), m0_q[i].writedata, pat);
      check($sformatf("stall_wr%0d_flag", i), {m0_q[i].read, m0_q[i].write}, 2'b01);
    end

    // Response path
    rsp_beat(1'b1, {64{8'hA5}}, 2'b00, "rsp_a5");
    rsp_beat(1'b1, {64{8'h5A}}, 2'b10, "rsp_5a");
    rsp_beat(1'b0, '0, 2'b00, "rsp_idle");

    // Throughput: 64 writes with no stall
    m0_q.delete();
    wait_seen = 1'b0;
    max_run = 0;
    for (int i = 0; i < 64; i++)
      send(1'b0, 1'b1, 27'(27'h1000 + i), 7'd2, {16{32'(i)}}, '1, $sformatf("tput%0d", i));
    idle();
    repeat (4) tick();
    check("tput_consecutive_writes", max_run, 64);
    check("tput_no_waitrequest", wait_seen, 1'b0);
    check("tput_beat_count", m0_q.size(), 64);
    if (m0_q.size() == 64) check("tput_last_addr", m0_q[63].address, 27'h103F);

    // Random stall, mixed reads/writes (including read+write together)
    m0_q.delete();
    s0_q.delete();
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      s0_debugaccess = 1'($urandom_range(0, 1));
      send(kind != 1, kind != 0, 27'($urandom), 7'($urandom), {16{$urandom}}, {2{$urandom}}, $sformatf("rand%0d", i));
    end
    idle();
    s0_debugaccess = 1'b0;
    rand_mode = 1'b0;
    repeat (8) tick();
    check("rand_s0_count", s0_q.size(), 40);
    check("rand_m0_count", m0_q.size(), s0_q.size());
    for (int i = 0; i < m0_q.size() && i < s0_q.size(); i++)
      check($sformatf("rand_cmd%0d", i), m0_q[i], s0_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
